control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that sits directly upstream of `System`: it replaces the hand-driven control vectors used in the testbenches and produces, every clock, the datapath and memory strobes for fetch and execute. It covers the fetch cycle, `ld`, `ldi`, `st`, `add`, `sub`, `mfhi`, `mflo`, `nop` and `halt`, and waits on `memory_done` for every memory access. Outputs connect port-for-port to the same-named `System` inputs. `Zhi_out`, `Inport_out`, `HIin`, `LOin`, `CONin` and `outport_in` are tied 0 at the `System` level.

## Interface
- DATA_WIDTH, 32, instruction width; opcode field is IR[DATA_WIDTH-1 -: 5].
- Clock  in  1  single clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-high reset.
- IR  in  DATA_WIDTH  instruction register contents from datapath.
- memory_done  in  1  memory access complete, sampled on rising edge.
- PCout, IncPC, PCin  out  1 each  PC drive / increment-through-ALU / PC load.
- MARin, MDRin, MDRout, IRin  out  1 each  MAR/MDR/IR strobes.
- Yin, Zin, Zlo_out, Cout, BAout  out  1 each  ALU-path strobes.
- HIout, LOout  out  1 each  HI/LO bus drive.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select and strobes.
- opcode  out  5  ALU operation code.
- Mem_Read, Mem_Write, Mem_enable512x32  out  1 each  memory controls.
- run  out  1  high unless halted.

## Operation
- Instruction opcodes: ld 00000, ldi 00001, st 00010, mfhi 00011, add 00100, sub 00101, mflo 01011, nop 11010, halt 11011. All other opcodes execute as nop.
- ALU codes on `opcode`: ADD 5'b00011, SUB 5'b00100. `opcode` is 0 when Zin=0.
- States: T0..T7, WAIT_F (fetch wait), WAIT_M (data wait), HALT. Outputs are a Moore decode of the state and IR[31:27]. Every strobe not listed for a state is 0.
- T0: PCout IncPC MARin Zin, opcode=ADD.
- T1: Zlo_out PCin MDRin Mem_Read Mem_enable512x32. Go to T2 if memory_done, else WAIT_F. WAIT_F holds MDRin Mem_Read Mem_enable512x32 until memory_done.
- T2: MDRout IRin. Next state: nop/illegal go to T0, halt goes to HALT, all others go to T3.
- mfhi/mflo T3: Gra Rin HIout (or LOout), then T0.
- add/sub: T3 Grb Rout Yin; T4 Grc Rout Zin with ADD or SUB; T5 Zlo_out Gra Rin, then T0.
- ldi: T3 Grb Rout BAout Yin; T4 Cout Zin ADD; T5 Zlo_out Gra Rin, then T0.
- ld: T3/T4 same as ldi; T5 Zlo_out MARin; T6 Mem_Read Mem_enable512x32 MDRin; T7 MDRout Gra Rin, then T0.
- st: T3/T4 same as ldi; T5 Zlo_out MARin; T6 Gra Rout MDRin (Mem_Read=0); T7 Mem_Write Mem_enable512x32, then T0.
- Memory waits: T6 (ld) and T7 (st) move to WAIT_M when memory_done=0. WAIT_M repeats the same strobes. The state advances on the first edge with memory_done=1.
- HALT: all strobes 0, run=0. Only clear exits HALT.

## Timing
- Reset: clear=1 forces state T0 and all outputs 0 immediately (asynchronous), with run=1 and opcode=0. While clear is high, T0 strobes are suppressed. The first T0 cycle starts on the first rising edge after clear falls.
- Reset mid-access: abandons any wait state. Memory and PC recovery belong to System.
- Instruction latency with memory_done high every cycle: nop 3 cycles, mfhi/mflo 4, add/sub/ldi 6, ld/st 8. Each wait cycle adds 1.
- IR is valid from T3 onward. Decode in T2 uses the IR value loaded at the end of T2, i.e. the next-state logic uses the IR input combinationally on the T2 edge. The bench holds IR stable after IRin.
- memory_done high in the same cycle as the request skips the wait state. memory_done outside T1/T6/T7/wait states is ignored.

## Structure
- Shared package `cpu_defs`: instruction opcode localparams, ALU code localparams, state encoding (4-bit).
- Single module. Optional sub-module `opcode_decoder` (IR[31:27] to one-hot class: LD, LDI, ST, ALU, MFHI, MFLO, HALT, NOP).

## Test plan
- Reset: assert clear mid-WAIT_F -> all outputs 0 at once; T0 strobes appear the first cycle after release.
- mfhi (IR=32'b00011_0110_0...0), memory_done tied 1 -> T0..T3 in 4 cycles; T3 shows Gra=Rin=HIout=1; back to T0.
- add (IR opcode 00100) -> T4 shows Zin=1 and opcode=5'b00011; T5 shows Zlo_out Gra Rin; 6 cycles total.
- ld with memory_done low for 3 cycles in T6 -> WAIT_M for 3 cycles with Mem_Read=MDRin=1; T7 on the release edge; 11 cycles total.
- st -> T6 has Gra Rout MDRin with Mem_Read=0; T7 has Mem_Write=Mem_enable512x32=1.
- halt (opcode 11011) -> run=0 after T2 and all strobes stay 0 for 20 cycles; clear returns run=1 and restarts fetch. Illegal opcode 11111 -> behaves as nop (3 cycles).

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control sequencer: instruction and ALU
// codes, FSM state encoding, instruction classes and the control-word layout.
package cpu_defs;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_MFHI = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MFLO = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_WAIT_F, S_WAIT_M, S_HALT
    } state_t;

    // One-hot instruction class; unknown opcodes land in nop.
    typedef struct packed {
        logic ld;
        logic ldi;
        logic st;
        logic alu;
        logic mfhi;
        logic mflo;
        logic halt;
        logic nop;
    } op_class_t;

    typedef struct packed {
        logic       pc_out;
        logic       inc_pc;
        logic       pc_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       zlo_out;
        logic       c_out;
        logic       ba_out;
        logic       hi_out;
        logic       lo_out;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       mem_read;
        logic       mem_write;
        logic       mem_en;
        logic [4:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and System: IR and memory_done in,
// every datapath and memory strobe out. Names match the System inputs.
interface control_sequencer_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] IR;
    logic                  memory_done;
    logic PCout, IncPC, PCin;
    logic MARin, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlo_out, Cout, BAout;
    logic HIout, LOout;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [4:0] opcode;
    logic Mem_Read, Mem_Write, Mem_enable512x32;
    logic run;

    modport master (
        input  IR, memory_done,
        output PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin,
        output Yin, Zin, Zlo_out, Cout, BAout, HIout, LOout,
        output Gra, Grb, Grc, Rin, Rout, opcode,
        output Mem_Read, Mem_Write, Mem_enable512x32, run
    );

    modport slave (
        output IR, memory_done,
        input  PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlo_out, Cout, BAout, HIout, LOout,
        input  Gra, Grb, Grc, Rin, Rout, opcode,
        input  Mem_Read, Mem_Write, Mem_enable512x32, run
    );
endinterface

// File: rtl/opcode_decoder.sv
// Maps the 5-bit instruction opcode to a one-hot class plus the add/sub select.
module opcode_decoder
    import cpu_defs::*;
(
    input  logic [4:0] op,
    output op_class_t  cls,
    output logic       is_sub
);

    // Pure decode; anything unrecognised is treated as nop.
    always_comb begin
        cls    = '0;
        is_sub = 1'b0;
        case (op)
            OP_LD:   cls.ld   = 1'b1;
            OP_LDI:  cls.ldi  = 1'b1;
            OP_ST:   cls.st   = 1'b1;
            OP_MFHI: cls.mfhi = 1'b1;
            OP_MFLO: cls.mflo = 1'b1;
            OP_ADD:  cls.alu  = 1'b1;
            OP_SUB: begin
                cls.alu = 1'b1;
                is_sub  = 1'b1;
            end
            OP_HALT: cls.halt = 1'b1;
            default: cls.nop  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving the System control inputs.
//
// state    | meaning
// T0       | PC -> MAR, PC+1 into Z
// T1       | Z -> PC, memory read of instruction
// WAIT_F   | instruction fetch waiting on memory_done
// T2       | MDR -> IR, decode
// T3..T5   | operand / ALU / writeback or address steps
// T6, T7   | data memory access (ld / st)
// WAIT_M   | data access waiting on memory_done, strobes held
// HALT     | stopped, all strobes 0, only clear exits
//
// Outputs are registered: the control word for the state being entered is
// computed from state_d, so outputs and state change on the same edge.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                Clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    state_t    state_q, state_d;
    ctrl_t     ctrl_q, ctrl_d;
    logic      run_q, run_d;
    logic      armed_q, armed_d;
    op_class_t cls;
    logic      is_sub;
    logic      md;

    assign md = bus.memory_done;

    opcode_decoder u_dec (
        .op     (bus.IR[DATA_WIDTH-1 -: 5]),
        .cls    (cls),
        .is_sub (is_sub)
    );

    // Next state, then the control word of that next state.
    always_comb begin
        // armed_q is clear only for the first edge after reset: that edge
        // enters T0 with its strobes instead of advancing to T1.
        armed_d = 1'b1;
        state_d = state_q;
        if (!armed_q) begin
            state_d = S_T0;
        end else begin
            case (state_q)
                S_T0:     state_d = S_T1;
                S_T1:     state_d = md ? S_T2 : S_WAIT_F;
                S_WAIT_F: state_d = md ? S_T2 : S_WAIT_F;
                S_T2:     state_d = cls.nop ? S_T0 : (cls.halt ? S_HALT : S_T3);
                S_T3:     state_d = (cls.mfhi | cls.mflo) ? S_T0 : S_T4;
                S_T4:     state_d = S_T5;
                S_T5:     state_d = (cls.ld | cls.st) ? S_T6 : S_T0;
                S_T6:     state_d = (cls.ld && !md) ? S_WAIT_M : S_T7;
                S_T7:     state_d = (cls.st && !md) ? S_WAIT_M : S_T0;
                S_WAIT_M: state_d = md ? (cls.ld ? S_T7 : S_T0) : S_WAIT_M;
                S_HALT:   state_d = S_HALT;
                default:  state_d = S_T0;
            endcase
        end

        ctrl_d = CTRL_IDLE;
        case (state_d)
            S_T0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.inc_pc = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.z_in   = 1'b1;
                ctrl_d.alu_op = ALU_ADD;
            end
            S_T1: begin
                ctrl_d.zlo_out  = 1'b1;
                ctrl_d.pc_in    = 1'b1;
                ctrl_d.mdr_in   = 1'b1;
                ctrl_d.mem_read = 1'b1;
                ctrl_d.mem_en   = 1'b1;
            end
            S_WAIT_F: begin
                ctrl_d.mdr_in   = 1'b1;
                ctrl_d.mem_read = 1'b1;
                ctrl_d.mem_en   = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            S_T3: begin
                if (cls.mfhi | cls.mflo) begin
                    ctrl_d.gra    = 1'b1;
                    ctrl_d.r_in   = 1'b1;
                    ctrl_d.hi_out = cls.mfhi;
                    ctrl_d.lo_out = cls.mflo;
                end else begin
                    ctrl_d.grb    = 1'b1;
                    ctrl_d.r_out  = 1'b1;
                    ctrl_d.y_in   = 1'b1;
                    ctrl_d.ba_out = ~cls.alu;
                end
            end
            S_T4: begin
                ctrl_d.z_in = 1'b1;
                if (cls.alu) begin
                    ctrl_d.grc    = 1'b1;
                    ctrl_d.r_out  = 1'b1;
                    ctrl_d.alu_op = is_sub ? ALU_SUB : ALU_ADD;
                end else begin
                    ctrl_d.c_out  = 1'b1;
                    ctrl_d.alu_op = ALU_ADD;
                end
            end
            S_T5: begin
                ctrl_d.zlo_out = 1'b1;
                if (cls.ld | cls.st) begin
                    ctrl_d.mar_in = 1'b1;
                end else begin
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.r_in = 1'b1;
                end
            end
            S_T6, S_T7, S_WAIT_M: begin
                // WAIT_M holds T6 strobes for ld and T7 strobes for st.
                if (cls.ld && state_d != S_T7) begin
                    ctrl_d.mem_read = 1'b1;
                    ctrl_d.mem_en   = 1'b1;
                    ctrl_d.mdr_in   = 1'b1;
                end else if (cls.ld) begin
                    ctrl_d.mdr_out = 1'b1;
                    ctrl_d.gra     = 1'b1;
                    ctrl_d.r_in    = 1'b1;
                end else if (state_d == S_T6) begin
                    ctrl_d.gra    = 1'b1;
                    ctrl_d.r_out  = 1'b1;
                    ctrl_d.mdr_in = 1'b1;
                end else begin
                    ctrl_d.mem_write = 1'b1;
                    ctrl_d.mem_en    = 1'b1;
                end
            end
            default: ctrl_d = CTRL_IDLE;
        endcase

        run_d = (state_d != S_HALT);
    end

    // State and registered control word; clear forces T0 with strobes off.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q <= S_T0;
            ctrl_q  <= CTRL_IDLE;
            run_q   <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            run_q   <= run_d;
            armed_q <= armed_d;
        end
    end

    assign bus.PCout            = ctrl_q.pc_out;
    assign bus.IncPC            = ctrl_q.inc_pc;
    assign bus.PCin             = ctrl_q.pc_in;
    assign bus.MARin            = ctrl_q.mar_in;
    assign bus.MDRin            = ctrl_q.mdr_in;
    assign bus.MDRout           = ctrl_q.mdr_out;
    assign bus.IRin             = ctrl_q.ir_in;
    assign bus.Yin              = ctrl_q.y_in;
    assign bus.Zin              = ctrl_q.z_in;
    assign bus.Zlo_out          = ctrl_q.zlo_out;
    assign bus.Cout             = ctrl_q.c_out;
    assign bus.BAout            = ctrl_q.ba_out;
    assign bus.HIout            = ctrl_q.hi_out;
    assign bus.LOout            = ctrl_q.lo_out;
    assign bus.Gra              = ctrl_q.gra;
    assign bus.Grb              = ctrl_q.grb;
    assign bus.Grc              = ctrl_q.grc;
    assign bus.Rin              = ctrl_q.r_in;
    assign bus.Rout             = ctrl_q.r_out;
    assign bus.opcode           = ctrl_q.alu_op;
    assign bus.Mem_Read         = ctrl_q.mem_read;
    assign bus.Mem_Write        = ctrl_q.mem_write;
    assign bus.Mem_enable512x32 = ctrl_q.mem_en;
    assign bus.run              = run_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch and every instruction
// class cycle by cycle and compares the full output word each cycle.
module tb_control_sequencer;

    logic Clock;
    logic clear;
    int   checks;
    int   errors;

    control_sequencer_if #(.DATA_WIDTH(32)) bus ();

    control_sequencer #(.DATA_WIDTH(32)) dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Output word: 22 strobes, run, then the 5-bit ALU code.
    logic [27:0] obs;
    assign obs = {bus.PCout, bus.IncPC, bus.PCin, bus.MARin, bus.MDRin,
                  bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlo_out,
                  bus.Cout, bus.BAout, bus.HIout, bus.LOout, bus.Gra,
                  bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.Mem_Read,
                  bus.Mem_Write, bus.Mem_enable512x32, bus.run, bus.opcode};

    localparam logic [27:0] PCOUT  = 28'h1 << 27;
    localparam logic [27:0] INCPC  = 28'h1 << 26;
    localparam logic [27:0] PCIN   = 28'h1 << 25;
    localparam logic [27:0] MARIN  = 28'h1 << 24;
    localparam logic [27:0] MDRIN  = 28'h1 << 23;
    localparam logic [27:0] MDROUT = 28'h1 << 22;
    localparam logic [27:0] IRIN   = 28'h1 << 21;
    localparam logic [27:0] YIN    = 28'h1 << 20;
    localparam logic [27:0] ZIN    = 28'h1 << 19;
    localparam logic [27:0] ZLO    = 28'h1 << 18;
    localparam logic [27:0] COUT   = 28'h1 << 17;
    localparam logic [27:0] BAOUT  = 28'h1 << 16;
    localparam logic [27:0] HIOUT  = 28'h1 << 15;
    localparam logic [27:0] LOOUT  = 28'h1 << 14;
    localparam logic [27:0] GRA    = 28'h1 << 13;
    localparam logic [27:0] GRB    = 28'h1 << 12;
    localparam logic [27:0] GRC    = 28'h1 << 11;
    localparam logic [27:0] RIN    = 28'h1 << 10;
    localparam logic [27:0] ROUT   = 28'h1 << 9;
    localparam logic [27:0] MRD    = 28'h1 << 8;
    localparam logic [27:0] MWR    = 28'h1 << 7;
    localparam logic [27:0] MEN    = 28'h1 << 6;
    localparam logic [27:0] RUN    = 28'h1 << 5;
    localparam logic [27:0] A_ADD  = 28'd3;
    localparam logic [27:0] A_SUB  = 28'd4;

    localparam logic [27:0] E_RST  = RUN;
    localparam logic [27:0] E_HALT = 28'h0;
    localparam logic [27:0] E_T0   = PCOUT | INCPC | MARIN | ZIN | RUN | A_ADD;
    localparam logic [27:0] E_T1   = ZLO | PCIN | MDRIN | MRD | MEN | RUN;
    localparam logic [27:0] E_WF   = MDRIN | MRD | MEN | RUN;
    localparam logic [27:0] E_T2   = MDROUT | IRIN | RUN;
    localparam logic [27:0] E_HI3  = GRA | RIN | HIOUT | RUN;
    localparam logic [27:0] E_LO3  = GRA | RIN | LOOUT | RUN;
    localparam logic [27:0] E_ALU3 = GRB | ROUT | YIN | RUN;
    localparam logic [27:0] E_ADD4 = GRC | ROUT | ZIN | RUN | A_ADD;
    localparam logic [27:0] E_SUB4 = GRC | ROUT | ZIN | RUN | A_SUB;
    localparam logic [27:0] E_WB5  = ZLO | GRA | RIN | RUN;
    localparam logic [27:0] E_IMM3 = GRB | ROUT | BAOUT | YIN | RUN;
    localparam logic [27:0] E_IMM4 = COUT | ZIN | RUN | A_ADD;
    localparam logic [27:0] E_MA5  = ZLO | MARIN | RUN;
    localparam logic [27:0] E_LD6  = MRD | MEN | MDRIN | RUN;
    localparam logic [27:0] E_LD7  = MDROUT | GRA | RIN | RUN;
    localparam logic [27:0] E_ST6  = GRA | ROUT | MDRIN | RUN;
    localparam logic [27:0] E_ST7  = MWR | MEN | RUN;

    task automatic chk(input string tag, input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge (one DUT cycle) and compare.
    task automatic cyc(input string tag, input logic [27:0] exp);
        @(negedge Clock);
        chk(tag, exp);
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op);
        return {op, 4'b0110, 23'h0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        checks = 0;
        errors = 0;
        clear = 1'b1;
        bus.IR = mk_ir(5'b11010);
        bus.memory_done = 1'b0;
        #1;
        chk("reset_async", E_RST);
        cyc("reset_held", E_RST);
        clear = 1'b0;

        // Fetch stalls in WAIT_F, then clear mid-wait.
        cyc("f_t0", E_T0);
        cyc("f_t1", E_T1);
        cyc("f_waitf1", E_WF);
        cyc("f_waitf2", E_WF);
        clear = 1'b1;
        #1;
        chk("clear_midwait", E_RST);
        cyc("clear_held", E_RST);
        clear = 1'b0;
        bus.memory_done = 1'b1;
        cyc("restart_t0", E_T0);

        // mfhi: 4 cycles
        bus.IR = mk_ir(5'b00011);
        cyc("mfhi_t1", E_T1);
        cyc("mfhi_t2", E_T2);
        cyc("mfhi_t3", E_HI3);
        cyc("mfhi_t0", E_T0);

        // add: 6 cycles
        bus.IR = mk_ir(5'b00100);
        cyc("add_t1", E_T1);
        cyc("add_t2", E_T2);
        cyc("add_t3", E_ALU3);
        cyc("add_t4", E_ADD4);
        cyc("add_t5", E_WB5);
        cyc("add_t0", E_T0);

        // sub
        bus.IR = mk_ir(5'b00101);
        cyc("sub_t1", E_T1);
        cyc("sub_t2", E_T2);
        cyc("sub_t3", E_ALU3);
        cyc("sub_t4", E_SUB4);
        cyc("sub_t5", E_WB5);
        cyc("sub_t0", E_T0);

        // ldi
        bus.IR = mk_ir(5'b00001);
        cyc("ldi_t1", E_T1);
        cyc("ldi_t2", E_T2);
        cyc("ldi_t3", E_IMM3);
        cyc("ldi_t4", E_IMM4);
        cyc("ldi_t5", E_WB5);
        cyc("ldi_t0", E_T0);

        // ld with memory_done low at the T6 edge and two WAIT_M edges: 11 cycles
        bus.IR = mk_ir(5'b00000);
        cyc("ld_t1", E_T1);
        cyc("ld_t2", E_T2);
        cyc("ld_t3", E_IMM3);
        cyc("ld_t4", E_IMM4);
        cyc("ld_t5", E_MA5);
        bus.memory_done = 1'b0;
        cyc("ld_t6", E_LD6);
        cyc("ld_waitm1", E_LD6);
        cyc("ld_waitm2", E_LD6);
        cyc("ld_waitm3", E_LD6);
        bus.memory_done = 1'b1;
        cyc("ld_t7", E_LD7);
        cyc("ld_t0", E_T0);

        // st: memory_done ignored in T6, one WAIT_M after T7
        bus.IR = mk_ir(5'b00010);
        cyc("st_t1", E_T1);
        cyc("st_t2", E_T2);
        cyc("st_t3", E_IMM3);
        cyc("st_t4", E_IMM4);
        cyc("st_t5", E_MA5);
        bus.memory_done = 1'b0;
        cyc("st_t6", E_ST6);
        cyc("st_t7", E_ST7);
        cyc("st_waitm", E_ST7);
        bus.memory_done = 1'b1;
        cyc("st_t0", E_T0);

        // illegal opcode behaves as nop: 3 cycles
        bus.IR = mk_ir(5'b11111);
        cyc("ill_t1", E_T1);
        cyc("ill_t2", E_T2);
        cyc("ill_t0", E_T0);

        // mflo with one fetch wait cycle
        bus.IR = mk_ir(5'b01011);
        bus.memory_done = 1'b0;
        cyc("mflo_t1", E_T1);
        cyc("mflo_waitf", E_WF);
        bus.memory_done = 1'b1;
        cyc("mflo_t2", E_T2);
        cyc("mflo_t3", E_LO3);
        cyc("mflo_t0", E_T0);

        // halt: stays stopped with memory_done toggling
        bus.IR = mk_ir(5'b11011);
        cyc("halt_t1", E_T1);
        cyc("halt_t2", E_T2);
        for (int i = 0; i < 20; i++) begin
            cyc("halt_hold", E_HALT);
            bus.memory_done = ~bus.memory_done;
        end
        bus.memory_done = 1'b1;
        clear = 1'b1;
        #1;
        chk("halt_clear", E_RST);
        @(negedge Clock);
        clear = 1'b0;
        bus.IR = mk_ir(5'b11010);
        cyc("halt_restart_t0", E_T0);

        // nop: 3 cycles
        cyc("nop_t1", E_T1);
        cyc("nop_t2", E_T2);
        cyc("nop_t0", E_T0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
